// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// default memory-wait tolerance and the saturating counter helper.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StDataStall = 2'd1,
      StMemWait   = 2'd2,
      StFault     = 2'd3
   } ctrlState_t;

   localparam int unsigned waitLimitDefault = 255;
   localparam logic [15:0] counterMax       = 16'hFFFF;

   function automatic logic [15:0] satInc(input logic [15:0] value);
      return (value == counterMax) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/hazard_compare.sv
// Compares one ID-stage source register against the EX and MEM destinations.
// Register $0 is hard-wired to zero, so it never creates a dependency.
module hazard_compare (
   input  logic       srcUsed,
   input  logic [4:0] src,
   input  logic       exWrite,
   input  logic [4:0] exAddr,
   input  logic       memWrite,
   input  logic [4:0] memAddr,
   output logic       hazard
);

   logic exMatch;
   logic memMatch;

   assign exMatch  = exWrite && (exAddr == src);
   assign memMatch = memWrite && (memAddr == src);
   assign hazard   = srcUsed && (src != 5'd0) && (exMatch || memMatch);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline without forwarding.
// Pipeline enables are combinational from the current state and inputs so a
// memory wait freezes the pipe in the same cycle; state, wait timer and
// performance counters are registered.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = waitLimitDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_usesRs,
   input  logic        id_usesRt,
   input  logic        ex_shouldWriteRegister,
   input  logic        mem_shouldWriteRegister,
   input  logic [4:0]  ex_registerWriteAddress,
   input  logic [4:0]  mem_registerWriteAddress,
   input  logic        shouldJumpOrBranch,
   input  logic        mem_access,
   input  logic        MIO_ready,
   input  logic        clearCounters,
   output logic        pcWriteEnable,
   output logic        ifidWriteEnable,
   output logic        exmemWriteEnable,
   output logic        ifidFlush,
   output logic        idexBubble,
   output logic        memwbBubble,
   output logic [1:0]  state,
   output logic        busFault,
   output logic [15:0] dataStallCycles,
   output logic [15:0] memWaitCycles
);

   // Timer value seen on the last tolerated wait cycle.
   localparam logic [7:0] waitLast = 8'(WAIT_LIMIT - 1);

   ctrlState_t  stateQ, stateD;
   logic [7:0]  waitTimerQ, waitTimerD;
   logic [15:0] dataStallQ, dataStallD;
   logic [15:0] memWaitQ, memWaitD;
   logic        rsHazard, rtHazard, rawHazard, memWait, inFault;

   hazard_compare rsCompare (
      .srcUsed  (id_usesRs),
      .src      (id_rs),
      .exWrite  (ex_shouldWriteRegister),
      .exAddr   (ex_registerWriteAddress),
      .memWrite (mem_shouldWriteRegister),
      .memAddr  (mem_registerWriteAddress),
      .hazard   (rsHazard)
   );

   hazard_compare rtCompare (
      .srcUsed  (id_usesRt),
      .src      (id_rt),
      .exWrite  (ex_shouldWriteRegister),
      .exAddr   (ex_registerWriteAddress),
      .memWrite (mem_shouldWriteRegister),
      .memAddr  (mem_registerWriteAddress),
      .hazard   (rtHazard)
   );

   assign rawHazard = rsHazard | rtHazard;
   assign memWait   = mem_access & ~MIO_ready;
   assign inFault   = (stateQ == StFault);

   assign state           = stateQ;
   assign busFault        = inFault;
   assign dataStallCycles = dataStallQ;
   assign memWaitCycles   = memWaitQ;

   // Pipeline enables and next state, by priority fault > wait > RAW > branch.
   always_comb begin
      pcWriteEnable    = 1'b1;
      ifidWriteEnable  = 1'b1;
      exmemWriteEnable = 1'b1;
      ifidFlush        = 1'b0;
      idexBubble       = 1'b0;
      memwbBubble      = 1'b0;
      stateD           = StRun;
      waitTimerD       = 8'd0;
      if (inFault) begin
         pcWriteEnable    = 1'b0;
         ifidWriteEnable  = 1'b0;
         exmemWriteEnable = 1'b0;
         stateD           = StFault;
         waitTimerD       = waitTimerQ;
      end else if (memWait) begin
         pcWriteEnable    = 1'b0;
         ifidWriteEnable  = 1'b0;
         exmemWriteEnable = 1'b0;
         memwbBubble      = 1'b1;
         waitTimerD       = waitTimerQ + 8'd1;
         stateD           = (waitTimerQ == waitLast) ? StFault : StMemWait;
      end else if (rawHazard) begin
         // Branch operands are not final yet, so the branch is ignored.
         pcWriteEnable   = 1'b0;
         ifidWriteEnable = 1'b0;
         idexBubble      = 1'b1;
         stateD          = StDataStall;
      end else begin
         ifidFlush = shouldJumpOrBranch;
      end
   end

   // Saturating performance counters; clear wins over increment, fault freezes.
   always_comb begin
      dataStallD = dataStallQ;
      memWaitD   = memWaitQ;
      if (!inFault) begin
         if (clearCounters) begin
            dataStallD = 16'd0;
            memWaitD   = 16'd0;
         end else if (memWait) begin
            memWaitD = satInc(memWaitQ);
         end else if (rawHazard) begin
            dataStallD = satInc(dataStallQ);
         end
      end
   end

   // State, wait timer and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ     <= StRun;
         waitTimerQ <= 8'd0;
         dataStallQ <= 16'd0;
         memWaitQ   <= 16'd0;
      end else begin
         stateQ     <= stateD;
         waitTimerQ <= waitTimerD;
         dataStallQ <= dataStallD;
         memWaitQ   <= memWaitD;
      end
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: memory-wait cycles tolerated before fault (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_rs, id_rt  input  5 each  source register fields of the instruction in ID.
REQ-005 SHALL have port id_usesRs, id_usesRt  input  1 each  ID instruction reads that source.
REQ-006 SHALL have port ex_shouldWriteRegister, mem_shouldWriteRegister  input  1 each  EX/MEM instruction writes a register.
REQ-007 SHALL have port ex_registerWriteAddress, mem_registerWriteAddress  input  5 each  EX/MEM destination register.
REQ-008 SHALL have port shouldJumpOrBranch  input  1  ID resolved a taken jump/branch.
REQ-009 SHALL have port mem_access  input  1  MEM-stage instruction is a load or store.
REQ-010 SHALL have port MIO_ready  input  1  memory completes the access this cycle.
REQ-011 SHALL have port clearCounters  input  1  synchronous clear of performance counters.
REQ-012 SHALL have port pcWriteEnable, ifidWriteEnable, exmemWriteEnable  output  1 each  pipeline register load enables.
REQ-013 SHALL have port ifidFlush, idexBubble, memwbBubble  output  1 each  load a NOP into IF/ID, ID/EX, MEM/WB.
REQ-014 SHALL have port state  output  2  current FSM state.
REQ-015 SHALL have port busFault  output  1  memory-wait timeout occurred.
REQ-016 SHALL have port dataStallCycles, memWaitCycles  output  16 each  saturating performance counters.

Function
REQ-017 SHALL detect a RAW hazard when (id_usesRs and id_rs!=0 and id_rs matches a writing EX or MEM destination) or the same for rt; no forwarding exists.
REQ-018 SHALL detect a memory wait when mem_access=1 and MIO_ready=0.
REQ-019 SHALL use states RUN=0, DATA_STALL=1, MEM_WAIT=2, FAULT=3; priority: FAULT > memory wait > RAW hazard > branch.
REQ-020 SHALL, on memory wait (non-FAULT), freeze combinationally in the same cycle: pcWriteEnable=ifidWriteEnable=exmemWriteEnable=0, idexBubble=0, ifidFlush=0, memwbBubble=1; next state MEM_WAIT.
REQ-021 SHALL, on RAW hazard without memory wait, drive pcWriteEnable=ifidWriteEnable=0, idexBubble=1, exmemWriteEnable=1, memwbBubble=0, ifidFlush=0; next state DATA_STALL.
REQ-022 SHALL ignore shouldJumpOrBranch whenever a hazard or memory wait is active (operands not final).
REQ-023 SHALL, with no hazard/wait, drive all write enables=1, bubbles=0, ifidFlush=shouldJumpOrBranch; next state RUN.
REQ-024 SHALL keep an 8-bit waitTimer: cleared whenever not in memory wait, incremented each memory-wait cycle; when a memory-wait cycle occurs with waitTimer==WAIT_LIMIT-1, next state FAULT.
REQ-025 SHALL in FAULT drive all write enables=0, all bubbles/flush=0, busFault=1, ignore all inputs, remain until reset.
REQ-026 SHALL treat the cycle MIO_ready rises as a normal cycle (REQ-021/023 apply); pipeline advances that cycle.
REQ-027 SHALL increment dataStallCycles per RAW-stall cycle and memWaitCycles per memory-wait cycle, saturating at 16'hFFFF; clearCounters=1 clears both, overriding increment; counters hold in FAULT.

Reset
REQ-028 SHALL on rst=0 immediately set state=RUN, waitTimer=0, counters=0, busFault=0; outputs follow REQ-023 with inputs, mid-wait reset abandons the wait.

Structure
REQ-029 SHALL place state encoding and WAIT_LIMIT default in shared package pipeline_ctrl_pkg.
REQ-030 SHALL instantiate one sub-module hazard_compare (one source vs both destinations, $0 excluded), used twice (rs, rt).

Verification
REQ-031 SHALL cover: EX writes $5, ID reads rs=$5 -> one cycle idexBubble=1, pcWriteEnable=0, state=1, dataStallCycles=1.
REQ-032 SHALL cover: ID reads $0, EX writes $0 -> no stall, all enables=1.
REQ-033 SHALL cover: mem_access=1, MIO_ready low 3 cycles -> 3 frozen cycles, memwbBubble=1, memWaitCycles=3, advance on 4th.
REQ-034 SHALL cover: RAW hazard plus shouldJumpOrBranch=1 -> ifidFlush=0; hazard clears -> ifidFlush=1 for one cycle.
REQ-035 SHALL cover: WAIT_LIMIT=4, MIO_ready held low -> state=3, busFault=1 after 4 wait cycles; rst low -> RUN.
REQ-036 SHALL cover: counter preset near 16'hFFFF with sustained stalls -> holds 16'hFFFF; clearCounters -> 0.
